// File: rtl/sparse_pair_issuer_if.sv
// rtl/sparse_pair_issuer_if.sv - compressed operand pair in, aligned dp_unit beats out
interface sparse_pair_issuer_if #(
  parameter int DW_DATA = 8,
  parameter int VEC_LEN = 16
);
  logic                       in_vld;
  logic                       in_rdy;
  logic [VEC_LEN-1:0]         in_bmp_a;
  logic [VEC_LEN-1:0]         in_bmp_b;
  logic [VEC_LEN*DW_DATA-1:0] in_val_a;
  logic [VEC_LEN*DW_DATA-1:0] in_val_b;
  logic                       stall;
  logic [DW_DATA-1:0]         out_a;
  logic [DW_DATA-1:0]         out_b;
  logic [1:0]                 out_valid;
  logic                       out_last;
  logic                       busy;

  modport master (
    output in_vld, in_bmp_a, in_bmp_b, in_val_a, in_val_b, stall,
    input  in_rdy, out_a, out_b, out_valid, out_last, busy
  );

  modport slave (
    input  in_vld, in_bmp_a, in_bmp_b, in_val_a, in_val_b, stall,
    output in_rdy, out_a, out_b, out_valid, out_last, busy
  );
endinterface

// File: rtl/sparse_pair_issuer.sv
// rtl/sparse_pair_issuer.sv - walks a sparse bitmap pair and issues aligned (a, b, valid) beats
// Define SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN to issue only positions where both operands are nonzero.
module sparse_pair_issuer #(
  parameter int DW_DATA = 8,
  parameter int VEC_LEN = 16,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  sparse_pair_issuer_if.slave bus
);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                     state_q, state_d;
  logic [VEC_LEN-1:0]         bmp_a_q, bmp_a_d, bmp_b_q, bmp_b_d, rem_q, rem_d;
  logic [VEC_LEN*DW_DATA-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic                       in_rdy_q, in_rdy_d, busy_q, busy_d, out_last_q, out_last_d;
  logic [1:0]                 out_valid_q, out_valid_d;
  logic [DW_DATA-1:0]         out_a_q, out_a_d, out_b_q, out_b_d;

  logic [IDX_W-1:0]           idx;
  logic [PTR_W-1:0]           ptr_a, ptr_b;
  logic [VEC_LEN-1:0]         rem_next;
  logic                       hit_a, hit_b;

`ifdef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
  // Skipped single-sided positions still consume slots, so derive pointers from the bitmap.
  function automatic logic [PTR_W-1:0] count_below(input logic [VEC_LEN-1:0] bmp,
                                                   input logic [IDX_W-1:0]   pos);
    logic [PTR_W-1:0] n;
    n = '0;
    for (int k = 0; k < VEC_LEN; k++)
      if (k < int'(pos) && bmp[k]) n = n + PTR_W'(1);
    return n;
  endfunction
`else
  logic [PTR_W-1:0]           pa_q, pa_d, pb_q, pb_d;
`endif

  always_comb begin
    state_d     = state_q;
    bmp_a_d     = bmp_a_q;
    bmp_b_d     = bmp_b_q;
    val_a_d     = val_a_q;
    val_b_d     = val_b_q;
    rem_d       = rem_q;
    in_rdy_d    = in_rdy_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_last_d  = out_last_q;
`ifndef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
    pa_d        = pa_q;
    pb_d        = pb_q;
`endif

    idx = '0;
    for (int k = VEC_LEN - 1; k >= 0; k--)
      if (rem_q[k]) idx = IDX_W'(k);
    rem_next = rem_q & ~(VEC_LEN'(1) << idx);
    // An empty walk must not pick up bitmap bit 0 as a hit.
    hit_a    = bmp_a_q[idx] & (|rem_q);
    hit_b    = bmp_b_q[idx] & (|rem_q);

`ifdef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
    ptr_a = count_below(bmp_a_q, idx);
    ptr_b = count_below(bmp_b_q, idx);
`else
    ptr_a = pa_q;
    ptr_b = pb_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!bus.stall) begin
          out_valid_d = 2'b00;
          out_a_d     = '0;
          out_b_d     = '0;
          out_last_d  = 1'b0;
        end
        if (bus.in_vld && in_rdy_q) begin
          bmp_a_d  = bus.in_bmp_a;
          bmp_b_d  = bus.in_bmp_b;
          val_a_d  = bus.in_val_a;
          val_b_d  = bus.in_val_b;
`ifdef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
          rem_d    = bus.in_bmp_a & bus.in_bmp_b;
`else
          rem_d    = bus.in_bmp_a | bus.in_bmp_b;
          pa_d     = '0;
          pb_d     = '0;
`endif
          state_d  = S_ISSUE;
          in_rdy_d = 1'b0;
          busy_d   = 1'b1;
        end else begin
          in_rdy_d = 1'b1;
        end
      end
      default: begin
        if (!bus.stall) begin
          out_valid_d = {hit_a, hit_b};
          out_a_d     = hit_a ? val_a_q[ptr_a*DW_DATA +: DW_DATA] : '0;
          out_b_d     = hit_b ? val_b_q[ptr_b*DW_DATA +: DW_DATA] : '0;
          out_last_d  = (rem_next == '0);
          rem_d       = rem_next;
`ifndef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
          pa_d        = pa_q + PTR_W'(hit_a);
          pb_d        = pb_q + PTR_W'(hit_b);
`endif
          if (rem_next == '0) begin
            state_d  = S_IDLE;
            in_rdy_d = 1'b1;
            busy_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bmp_a_q     <= '0;
      bmp_b_q     <= '0;
      val_a_q     <= '0;
      val_b_q     <= '0;
      rem_q       <= '0;
      in_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 2'b00;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_last_q  <= 1'b0;
`ifndef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
      pa_q        <= '0;
      pb_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      bmp_a_q     <= bmp_a_d;
      bmp_b_q     <= bmp_b_d;
      val_a_q     <= val_a_d;
      val_b_q     <= val_b_d;
      rem_q       <= rem_d;
      in_rdy_q    <= in_rdy_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_last_q  <= out_last_d;
`ifndef SPARSE_PAIR_ISSUER_INTERSECT_ONLY_EN
      pa_q        <= pa_d;
      pb_q        <= pb_d;
`endif
    end
  end

  assign bus.in_rdy    = in_rdy_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_last  = out_last_q;
endmodule
